reg_ring_initiator: RTL and testbench

- Head-of-ring master for the UDP register ring that the datapath modules (crypto and peers) sit on.
- Accepts one register read/write from the core side and launches it onto the ring as a one-cycle request.
- Waits for the transaction to return around the ring, then reports the acked data, unacked status or timeout back to the core.
- Closes the ring: its ring outputs feed the first user module, and its ring inputs come from the last.

---
 rtl/reg_ring_initiator_pkg.sv | 30 +++
 rtl/reg_ring_initiator_if.sv | 58 +++++
 rtl/reg_ring_initiator.sv | 193 +++++++++++++++++++
 tb/tb_reg_ring_initiator.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_ring_initiator_pkg.sv
// -----------------------------------------------------------------------------
// reg_ring_pkg
// Shared definitions for the register-ring head master: FSM state encoding,
// completion status codes, the filler word returned for unacked/timed-out
// transactions, and the default ring field widths.
// -----------------------------------------------------------------------------
package reg_ring_pkg;

    // Default ring field widths
    localparam int RING_ADDR_WIDTH = 23;
    localparam int RING_DATA_WIDTH = 32;
    localparam int RING_SRC_WIDTH  = 2;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Completion status reported to the core alongside core_done
    localparam logic [1:0] ST_ACK     = 2'b00;
    localparam logic [1:0] ST_UNACK   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Data word reported when the ring did not acknowledge the transaction
    localparam logic [31:0] UNACKED_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/reg_ring_initiator_if.sv
// -----------------------------------------------------------------------------
// Interfaces for the register-ring head master.
//
// reg_ring_core_if : core-side single-transaction request/completion bus.
//   master = core (drives core_req/core_rd_wr_L/core_addr/core_wr_data)
//   slave  = ring initiator (drives core_busy/core_done/core_rd_data/core_status)
//
// reg_ring_bus_if  : one hop of the register ring.
//   master = the stage driving the hop, slave = the stage receiving it.
// -----------------------------------------------------------------------------
interface reg_ring_core_if
    import reg_ring_pkg::*;
#(
    parameter int AW = RING_ADDR_WIDTH,
    parameter int DW = RING_DATA_WIDTH
);
    logic          core_req;
    logic          core_rd_wr_L;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wr_data;
    logic          core_busy;
    logic          core_done;
    logic [DW-1:0] core_rd_data;
    logic [1:0]    core_status;

    modport master (
        output core_req, core_rd_wr_L, core_addr, core_wr_data,
        input  core_busy, core_done, core_rd_data, core_status
    );

    modport slave (
        input  core_req, core_rd_wr_L, core_addr, core_wr_data,
        output core_busy, core_done, core_rd_data, core_status
    );
endinterface

interface reg_ring_bus_if
    import reg_ring_pkg::*;
#(
    parameter int AW = RING_ADDR_WIDTH,
    parameter int DW = RING_DATA_WIDTH,
    parameter int SW = RING_SRC_WIDTH
);
    logic          reg_req;
    logic          reg_ack;
    logic          reg_rd_wr_L;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_data;
    logic [SW-1:0] reg_src;

    modport master (
        output reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
    );

    modport slave (
        input  reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src
    );
endinterface

// File: rtl/reg_ring_initiator.sv
// -----------------------------------------------------------------------------
// reg_ring_initiator
// Head-of-ring master for the register ring. Accepts one read/write from the
// core, launches it onto the ring as a one-cycle request, waits for it to come
// back around, and reports acked data, unacked status or timeout to the core.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-low reset
//   core   : core-side request/completion bus (slave side)
//   o_ring : ring output toward the first user module (master side)
//   i_ring : ring return from the last user module (slave side)
//
// All outputs are registered: the combinational process computes the value
// each output must hold in the next cycle, the sequential process stores it.
// -----------------------------------------------------------------------------
module reg_ring_initiator
    import reg_ring_pkg::*;
#(
    parameter int                           UDP_REG_ADDR_WIDTH  = RING_ADDR_WIDTH,
    parameter int                           CPCI_NF2_DATA_WIDTH = RING_DATA_WIDTH,
    parameter int                           UDP_REG_SRC_WIDTH   = RING_SRC_WIDTH,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID              = '0,
    parameter int                           TIMEOUT             = 255
) (
    input  logic           clk,
    input  logic           reset,
    reg_ring_core_if.slave core,
    reg_ring_bus_if.master o_ring,
    reg_ring_bus_if.slave  i_ring
);

    localparam int AW = UDP_REG_ADDR_WIDTH;
    localparam int DW = CPCI_NF2_DATA_WIDTH;
    localparam int SW = UDP_REG_SRC_WIDTH;

    localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [DW-1:0] FILLER   = DW'(UNACKED_DATA);

    // State, wait counter and latched transaction
    state_t        r_state,       w_state_nxt;
    logic [7:0]    r_cnt,         w_cnt_nxt;
    logic          r_lat_rd_wr_L, w_lat_rd_wr_L;
    logic [AW-1:0] r_lat_addr,    w_lat_addr;
    logic [DW-1:0] r_lat_wr_data, w_lat_wr_data;

    // Registered outputs
    logic          r_req_out,     w_req_out;
    logic          r_ack_out,     w_ack_out;
    logic          r_rd_wr_L_out, w_rd_wr_L_out;
    logic [AW-1:0] r_addr_out,    w_addr_out;
    logic [DW-1:0] r_data_out,    w_data_out;
    logic [SW-1:0] r_src_out,     w_src_out;
    logic          r_busy,        w_busy;
    logic          r_done,        w_done;
    logic [DW-1:0] r_rd_data,     w_rd_data;
    logic [1:0]    r_status,      w_status;

    // Only our own transaction counts: request flag, our source tag and the
    // address we launched must all come back.
    logic w_match;
    assign w_match = i_ring.reg_req
                  && (i_ring.reg_src  == SRC_ID)
                  && (i_ring.reg_addr == r_lat_addr);

    // The returned rd_wr_L flag carries nothing the initiator needs.
    logic w_unused_rd_wr_L;
    assign w_unused_rd_wr_L = i_ring.reg_rd_wr_L;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_lat_rd_wr_L = r_lat_rd_wr_L;
        w_lat_addr    = r_lat_addr;
        w_lat_wr_data = r_lat_wr_data;
        w_req_out     = 1'b0;
        w_ack_out     = 1'b0;
        w_rd_wr_L_out = 1'b0;
        w_addr_out    = '0;
        w_data_out    = '0;
        w_src_out     = '0;
        w_done        = 1'b0;
        w_rd_data     = r_rd_data;
        w_status      = r_status;

        case (r_state)
            IDLE: begin
                if (core.core_req) begin
                    w_lat_rd_wr_L = core.core_rd_wr_L;
                    w_lat_addr    = core.core_addr;
                    w_lat_wr_data = core.core_wr_data;
                    // Launch values appear on the ring during the ISSUE cycle
                    w_req_out     = 1'b1;
                    w_rd_wr_L_out = core.core_rd_wr_L;
                    w_addr_out    = core.core_addr;
                    w_data_out    = core.core_wr_data;
                    w_src_out     = SRC_ID;
                    w_state_nxt   = ISSUE;
                end
            end

            ISSUE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT;
            end

            WAIT: begin
                // A match in the final counted cycle still wins over timeout
                if (w_match) begin
                    w_done      = 1'b1;
                    w_state_nxt = DONE;
                    if (i_ring.reg_ack) begin
                        w_status  = ST_ACK;
                        w_rd_data = r_lat_rd_wr_L ? i_ring.reg_data : r_lat_wr_data;
                    end else begin
                        w_status  = ST_UNACK;
                        w_rd_data = FILLER;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_done      = 1'b1;
                    w_status    = ST_TIMEOUT;
                    w_rd_data   = FILLER;
                    w_state_nxt = DONE;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy = (w_state_nxt != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_lat_rd_wr_L <= 1'b0;
            r_lat_addr    <= '0;
            r_lat_wr_data <= '0;
            r_req_out     <= 1'b0;
            r_ack_out     <= 1'b0;
            r_rd_wr_L_out <= 1'b0;
            r_addr_out    <= '0;
            r_data_out    <= '0;
            r_src_out     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_data     <= '0;
            r_status      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_lat_rd_wr_L <= w_lat_rd_wr_L;
            r_lat_addr    <= w_lat_addr;
            r_lat_wr_data <= w_lat_wr_data;
            r_req_out     <= w_req_out;
            r_ack_out     <= w_ack_out;
            r_rd_wr_L_out <= w_rd_wr_L_out;
            r_addr_out    <= w_addr_out;
            r_data_out    <= w_data_out;
            r_src_out     <= w_src_out;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_rd_data     <= w_rd_data;
            r_status      <= w_status;
        end
    end

    assign o_ring.reg_req     = r_req_out;
    assign o_ring.reg_ack     = r_ack_out;
    assign o_ring.reg_rd_wr_L = r_rd_wr_L_out;
    assign o_ring.reg_addr    = r_addr_out;
    assign o_ring.reg_data    = r_data_out;
    assign o_ring.reg_src     = r_src_out;

    assign core.core_busy     = r_busy;
    assign core.core_done     = r_done;
    assign core.core_rd_data  = r_rd_data;
    assign core.core_status   = r_status;

endmodule

// File: tb/tb_reg_ring_initiator.sv
// -----------------------------------------------------------------------------
// tb_reg_ring_initiator
// Closes the ring through a two-stage responder (addresses with the top bit
// set are acked; 0x40_0010 reads back 0x1234_5678), with an injection port
// for stray/foreign returns. A transaction-level model predicts every output
// for every cycle; directed scenarios pin latencies and values by hand.
// -----------------------------------------------------------------------------
module tb_reg_ring_initiator;

    localparam int         AW      = 23;
    localparam int         DW      = 32;
    localparam int         SW      = 2;
    localparam int         TIMEOUT = 255;
    localparam logic [1:0] SRC_ID  = 2'd0;

    logic clk = 1'b0;
    logic rst_n;

    initial forever #5 clk = ~clk;

    reg_ring_core_if #(.AW(AW), .DW(DW))          core_bus ();
    reg_ring_bus_if  #(.AW(AW), .DW(DW), .SW(SW)) ring_o ();
    reg_ring_bus_if  #(.AW(AW), .DW(DW), .SW(SW)) ring_i ();

    reg_ring_initiator #(
        .UDP_REG_ADDR_WIDTH  (AW),
        .CPCI_NF2_DATA_WIDTH (DW),
        .UDP_REG_SRC_WIDTH   (SW),
        .SRC_ID              (SRC_ID),
        .TIMEOUT             (TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .core   (core_bus),
        .o_ring (ring_o),
        .i_ring (ring_i)
    );

    // ---------------- ring responder + injection ----------------
    typedef struct packed {
        logic          req;
        logic          ack;
        logic          rd_wr_L;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } ring_t;

    ring_t s0 = '0;
    ring_t s1 = '0;
    ring_t inj = '0;
    ring_t ret;
    logic  inj_en  = 1'b0;
    logic  ring_ok = 1'b1;

    function automatic logic [DW-1:0] rd_value(input logic [AW-1:0] a);
        if (a == 23'h40_0010) return 32'h1234_5678;
        return {9'h0, a} ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        s0.req     <= ring_ok & ring_o.reg_req;
        s0.ack     <= ring_o.reg_addr[AW-1];
        s0.rd_wr_L <= ring_o.reg_rd_wr_L;
        s0.addr    <= ring_o.reg_addr;
        s0.data    <= ring_o.reg_rd_wr_L ? rd_value(ring_o.reg_addr) : ring_o.reg_data;
        s0.src     <= ring_o.reg_src;
        s1         <= s0;
    end

    assign ret                = inj_en ? inj : s1;
    assign ring_i.reg_req     = ret.req;
    assign ring_i.reg_ack     = ret.ack;
    assign ring_i.reg_rd_wr_L = ret.rd_wr_L;
    assign ring_i.reg_addr    = ret.addr;
    assign ring_i.reg_data    = ret.data;
    assign ring_i.reg_src     = ret.src;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int req_cyc = 0;
    int req_hi_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- transaction-level model ----------------
    // m_age: 0 idle, 1 launch visible, k>=2 means k-2 wait cycles elapsed.
    int            m_age  = 0;
    bit            m_done = 1'b0;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    logic          e_req = 0, e_rdwr = 0, e_busy = 0, e_done = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0, e_rd_data = '0;
    logic [SW-1:0] e_src = '0;
    logic [1:0]    e_status = '0;

    // Compare at negedge, then predict the outputs after the next posedge
    // from the inputs that edge will sample (they are stable from here).
    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            m_age = 0; m_done = 0;
            e_req = 0; e_rdwr = 0; e_busy = 0; e_done = 0;
            e_addr = '0; e_data = '0; e_src = '0; e_rd_data = '0; e_status = '0;
        end

        check("req_out",   ring_o.reg_req,       e_req);
        check("ack_out",   ring_o.reg_ack,       1'b0);
        check("rdwr_out",  ring_o.reg_rd_wr_L,   e_rdwr);
        check("addr_out",  ring_o.reg_addr,      e_addr);
        check("data_out",  ring_o.reg_data,      e_data);
        check("src_out",   ring_o.reg_src,       e_src);
        check("busy",      core_bus.core_busy,   e_busy);
        check("done",      core_bus.core_done,   e_done);
        check("rd_data",   core_bus.core_rd_data, e_rd_data);
        check("status",    core_bus.core_status, e_status);

        if (ring_o.reg_req === 1'b1) begin req_cyc = cyc; req_hi_cnt++; end
        if (core_bus.core_done === 1'b1) begin done_cyc = cyc; done_cnt++; end

        if (rst_n === 1'b1) begin
            e_req = 0; e_rdwr = 0; e_addr = '0; e_data = '0; e_src = '0; e_done = 0;
            if (m_done) begin
                m_done = 0;
                m_age  = 0;
            end else if (m_age == 0) begin
                if (core_bus.core_req) begin
                    m_rd = core_bus.core_rd_wr_L;
                    m_addr = core_bus.core_addr;
                    m_wdata = core_bus.core_wr_data;
                    e_req = 1; e_rdwr = m_rd; e_addr = m_addr; e_data = m_wdata; e_src = SRC_ID;
                    m_age = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                if (ret.req && ret.src == SRC_ID && ret.addr == m_addr) begin
                    e_done = 1; m_done = 1;
                    e_status  = ret.ack ? 2'b00 : 2'b01;
                    e_rd_data = !ret.ack ? 32'hDEAD_BEEF : (m_rd ? ret.data : m_wdata);
                end else if (m_age - 2 == TIMEOUT - 1) begin
                    e_done = 1; m_done = 1;
                    e_status = 2'b10; e_rd_data = 32'hDEAD_BEEF;
                end else begin
                    m_age++;
                end
            end
            e_busy = (m_age != 0);
        end
    end

    // ---------------- stimulus helpers (all at posedge+#1) ----------------
    task automatic wait_idle();
        int k = 0;
        while (core_bus.core_busy !== 1'b0 && k < 400) begin
            @(posedge clk); #1; k++;
        end
        check("idle_reached", core_bus.core_busy, 1'b0);
    endtask

    task automatic start_txn(input logic rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int s);
        wait_idle();
        core_bus.core_req = 1'b1;
        core_bus.core_rd_wr_L = rd;
        core_bus.core_addr = a;
        core_bus.core_wr_data = d;
        @(posedge clk); #1;
        s = cyc;
        core_bus.core_req = 1'b0;
    endtask

    task automatic pulse_req(input logic [AW-1:0] a);
        core_bus.core_req = 1'b1;
        core_bus.core_rd_wr_L = 1'b1;
        core_bus.core_addr = a;
        @(posedge clk); #1;
        core_bus.core_req = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int budget);
        int k = 0;
        while (done_cnt == n0 && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check("done_seen", 64'(done_cnt != n0), 1);
        @(posedge clk); #1;
    endtask

    function automatic ring_t mk_ret(input logic ack, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic [SW-1:0] src);
        ring_t r;
        r.req = 1'b1; r.ack = ack; r.rd_wr_L = 1'b1; r.addr = a; r.data = d; r.src = src;
        return r;
    endfunction

    task automatic inject(input ring_t r);
        inj = r; inj_en = 1'b1;
        @(posedge clk); #1;
        inj_en = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed + random scenarios ----------------
    initial begin
        int s, n0, n1, h0;
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        rst_n = 1'b0;
        core_bus.core_req = 1'b0;
        core_bus.core_rd_wr_L = 1'b0;
        core_bus.core_addr = '0;
        core_bus.core_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    core_bus.core_busy, 0);
        check("rst_req_out", ring_o.reg_req, 0);
        check("rst_status",  core_bus.core_status, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Acked read: launch at edge S, 2 ring stages, sampled at S+3
        n0 = done_cnt;
        start_txn(1'b1, 23'h40_0010, '0, s);
        wait_done(n0, 20);
        check("rd_latency", 64'(done_cyc - s), 3);
        check("rd_status",  core_bus.core_status, 2'b00);
        check("rd_data_lit", core_bus.core_rd_data, 32'h1234_5678);

        // Acked write: data echoes the written word, single request cycle
        n0 = done_cnt; h0 = req_hi_cnt;
        start_txn(1'b0, 23'h40_0014, 32'hCAFE_0001, s);
        wait_done(n0, 20);
        check("wr_status",   core_bus.core_status, 2'b00);
        check("wr_data_lit", core_bus.core_rd_data, 32'hCAFE_0001);
        check("wr_req_1cyc", 64'(req_hi_cnt - h0), 1);

        // Unmapped read: returned with ack=0
        n0 = done_cnt;
        start_txn(1'b1, 23'h00_0100, '0, s);
        wait_done(n0, 20);
        check("unack_status", core_bus.core_status, 2'b01);
        check("unack_data",   core_bus.core_rd_data, 32'hDEAD_BEEF);

        // Broken ring: timeout 256 cycles after the request, late return ignored
        ring_ok = 1'b0;
        n0 = done_cnt;
        start_txn(1'b1, 23'h40_0020, '0, s);
        wait_done(n0, 300);
        check("to_latency", 64'(done_cyc - req_cyc), 256);
        check("to_status",  core_bus.core_status, 2'b10);
        check("to_data",    core_bus.core_rd_data, 32'hDEAD_BEEF);
        repeat (10) begin @(posedge clk); #1; end
        n1 = done_cnt;
        inject(mk_ret(1'b1, 23'h40_0020, 32'h7777_7777, SRC_ID));
        repeat (20) begin @(posedge clk); #1; end
        check("late_ignored", 64'(done_cnt), 64'(n1));

        // Re-pulse while busy and foreign/wrong-address returns are ignored
        n0 = done_cnt; h0 = req_hi_cnt;
        start_txn(1'b1, 23'h40_0030, '0, s);
        pulse_req(23'h40_0044);
        inject(mk_ret(1'b1, 23'h40_0030, 32'h1111_1111, 2'd1));
        inject(mk_ret(1'b1, 23'h40_0034, 32'h2222_2222, SRC_ID));
        repeat (3) begin @(posedge clk); #1; end
        check("still_busy", core_bus.core_busy, 1'b1);
        check("no_early_done", 64'(done_cnt), 64'(n0));
        inject(mk_ret(1'b1, 23'h40_0030, 32'h0BAD_F00D, SRC_ID));
        wait_done(n0, 20);
        check("fg_status", core_bus.core_status, 2'b00);
        check("fg_data",   core_bus.core_rd_data, 32'h0BAD_F00D);
        check("fg_one_req", 64'(req_hi_cnt - h0), 1);
        repeat (5) begin @(posedge clk); #1; end
        check("fg_one_done", 64'(done_cnt - n0), 1);

        // Reset during WAIT clears outputs at once; the abandoned return is ignored
        start_txn(1'b1, 23'h40_0040, '0, s);
        repeat (5) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",    core_bus.core_busy, 0);
        check("mid_rst_rd_data", core_bus.core_rd_data, 0);
        check("mid_rst_status",  core_bus.core_status, 0);
        check("mid_rst_done",    core_bus.core_done, 0);
        check("mid_rst_req",     ring_o.reg_req, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n1 = done_cnt;
        repeat (2) begin @(posedge clk); #1; end
        inject(mk_ret(1'b1, 23'h40_0040, 32'h3333_3333, SRC_ID));
        repeat (5) begin @(posedge clk); #1; end
        check("post_rst_ignored", 64'(done_cnt), 64'(n1));
        ring_ok = 1'b1;
        n0 = done_cnt;
        start_txn(1'b1, 23'h40_0010, '0, s);
        wait_done(n0, 20);
        check("post_rst_status", core_bus.core_status, 2'b00);
        check("post_rst_data",   core_bus.core_rd_data, 32'h1234_5678);

        // Random traffic, occasional broken ring and busy re-pulses
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            a  = AW'($urandom);
            d  = $urandom;
            ring_ok = ($urandom_range(0, 9) != 0);
            n0 = done_cnt;
            start_txn(rd, a, d, s);
            if ($urandom_range(0, 1) == 1) pulse_req(AW'($urandom));
            wait_done(n0, 300);
            check("rand_one_done", 64'(done_cnt - n0), 1);
        end
        ring_ok = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
